// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter sharing one SRAM-like slave port among NUM_REQ masters.
// An in-order ID FIFO routes each slave response back to the master that issued it.
module sram_like_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [NUM_REQ-1:0]                 m_req,
  input  logic [NUM_REQ-1:0]                 m_wr,
  input  logic [2*NUM_REQ-1:0]               m_size,
  input  logic [4*NUM_REQ-1:0]               m_wstrb,
  input  logic [32*NUM_REQ-1:0]              m_addr,
  input  logic [32*NUM_REQ-1:0]              m_wdata,
  output logic [NUM_REQ-1:0]                 m_addr_ok,
  output logic [NUM_REQ-1:0]                 m_data_ok,
  output logic [31:0]                        m_rdata,
  output logic                               s_req,
  output logic                               s_wr,
  output logic [1:0]                         s_size,
  output logic [3:0]                         s_wstrb,
  output logic [31:0]                        s_addr,
  output logic [31:0]                        s_wdata,
  input  logic                               s_addr_ok,
  input  logic                               s_data_ok,
  input  logic [31:0]                        s_rdata,
  output logic [$clog2(OUTSTANDING+1)-1:0]   outstanding,
  output logic                               err_spurious
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int PTRW = $clog2(OUTSTANDING);
  localparam int CNTW = $clog2(OUTSTANDING+1);

  typedef enum logic [0:0] {ARB = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_r;
  logic [IDW-1:0]  grant_r;
  logic [IDW-1:0]  rr_r;
  logic [IDW-1:0]  fifo_r [OUTSTANDING];
  logic [PTRW-1:0] wr_ptr_r;
  logic [PTRW-1:0] rd_ptr_r;
  logic [CNTW-1:0] count_r;
  logic            err_r;

  logic [IDW-1:0]  pick_s;
  logic [IDW-1:0]  grant_s;
  logic [IDW-1:0]  head_s;
  logic [IDW-1:0]  rr_next_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            s_req_s;
  logic            push_s;
  logic            pop_s;

  // Round-robin pick: scan downward so the smallest offset from rr_r wins.
  always_comb begin
    pick_s = rr_r;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (m_req[(int'(rr_r) + k) % NUM_REQ]) begin
        pick_s = IDW'((int'(rr_r) + k) % NUM_REQ);
      end else begin
        pick_s = pick_s;
      end
    end
  end

  // Grant source, handshakes and response routing.
  always_comb begin
    fifo_full_s  = (count_r == CNTW'(OUTSTANDING));
    fifo_empty_s = (count_r == {CNTW{1'b0}});
    if (!aresetn) begin
      s_req_s = 1'b0;
      grant_s = grant_r;
    end else if (state_r == HOLD) begin
      s_req_s = 1'b1;
      grant_s = grant_r;
    end else begin
      s_req_s = !fifo_full_s && (|m_req);
      grant_s = pick_s;
    end
    push_s    = s_req_s & s_addr_ok;
    pop_s     = aresetn & s_data_ok & !fifo_empty_s;
    head_s    = fifo_r[rd_ptr_r];
    rr_next_s = (grant_s == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : grant_s + 1'b1;
    m_addr_ok = push_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_s) : {NUM_REQ{1'b0}};
    m_data_ok = pop_s  ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << head_s)  : {NUM_REQ{1'b0}};
  end

  assign s_req        = s_req_s;
  assign s_wr         = m_wr[grant_s];
  assign s_size       = m_size[2*int'(grant_s) +: 2];
  assign s_wstrb      = m_wstrb[4*int'(grant_s) +: 4];
  assign s_addr       = m_addr[32*int'(grant_s) +: 32];
  assign s_wdata      = m_wdata[32*int'(grant_s) +: 32];
  assign m_rdata      = s_rdata;
  assign outstanding  = count_r;
  assign err_spurious = err_r;

  // Arbitration FSM, ID FIFO and sticky error flag.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r  <= ARB;
      grant_r  <= {IDW{1'b0}};
      rr_r     <= {IDW{1'b0}};
      wr_ptr_r <= {PTRW{1'b0}};
      rd_ptr_r <= {PTRW{1'b0}};
      count_r  <= {CNTW{1'b0}};
      err_r    <= 1'b0;
      for (int i = 0; i < OUTSTANDING; i++) fifo_r[i] <= {IDW{1'b0}};
    end else begin
      case (state_r)
        ARB: begin
          if (s_req_s && !s_addr_ok) begin
            state_r <= HOLD;
            grant_r <= pick_s;
          end else begin
            state_r <= ARB;
          end
        end
        HOLD:    state_r <= s_addr_ok ? ARB : HOLD;
        default: state_r <= ARB;
      endcase
      if (push_s) begin
        fifo_r[wr_ptr_r] <= grant_s;
        wr_ptr_r         <= wr_ptr_r + 1'b1;
        rr_r             <= rr_next_s;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      if (push_s && !pop_s) begin
        count_r <= count_r + 1'b1;
      end else if (pop_s && !push_s) begin
        count_r <= count_r - 1'b1;
      end
      if (s_data_ok && fifo_empty_s) err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized bench for sram_like_arbiter against a queue-based model of
// round-robin grant, in-order response routing and the in-flight limit.
module tb_sram_like_arbiter;
  localparam int NR  = 2;
  localparam int OUT = 4;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [NR-1:0]    m_req, m_wr, m_addr_ok, m_data_ok;
  logic [2*NR-1:0]  m_size;
  logic [4*NR-1:0]  m_wstrb;
  logic [32*NR-1:0] m_addr, m_wdata;
  logic [31:0]      m_rdata, s_addr, s_wdata, s_rdata;
  logic             s_req, s_wr, s_addr_ok, s_data_ok, err_spurious;
  logic [1:0]       s_size;
  logic [3:0]       s_wstrb;
  logic [2:0]       outstanding;

  sram_like_arbiter #(.NUM_REQ(NR), .OUTSTANDING(OUT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_rdata(m_rdata), .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
    .s_rdata(s_rdata), .outstanding(outstanding), .err_spurious(err_spurious)
  );

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int            q[$];
  int            rr   = 0;
  int            pend = -1;
  logic          exp_err = 1'b0;
  logic [NR-1:0] aok_prev = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: evaluate expectations at the falling edge, then advance the model.
  task automatic cycle();
    int            g;
    logic          sreq;
    logic [NR-1:0] eaok, edok;
    @(negedge aclk);
    g = -1;
    if (aresetn) begin
      if (pend >= 0) g = pend;
      else if (q.size() < OUT)
        for (int k = 0; k < NR; k++)
          if (g < 0 && m_req[(rr + k) % NR]) g = (rr + k) % NR;
    end
    sreq = (g >= 0);
    eaok = '0;
    if (sreq && s_addr_ok) eaok[g] = 1'b1;
    edok = '0;
    if (aresetn && s_data_ok && q.size() > 0) edok[q[0]] = 1'b1;
    chk("s_req", s_req, sreq);
    chk("m_addr_ok", m_addr_ok, eaok);
    chk("m_data_ok", m_data_ok, edok);
    chk("outstanding", outstanding, q.size());
    chk("err_spurious", err_spurious, exp_err);
    chk("m_rdata", m_rdata, s_rdata);
    if (sreq)
      chk("s_fields", {s_wr, s_size, s_wstrb, s_addr, s_wdata},
          {m_wr[g], m_size[2*g +: 2], m_wstrb[4*g +: 4], m_addr[32*g +: 32], m_wdata[32*g +: 32]});
    if (!aresetn) begin
      q.delete(); rr = 0; pend = -1; exp_err = 1'b0;
    end else begin
      if (s_data_ok) begin
        if (q.size() > 0) void'(q.pop_front());
        else exp_err = 1'b1;
      end
      if (sreq && s_addr_ok) begin
        q.push_back(g); rr = (g + 1) % NR; pend = -1;
      end else if (sreq) begin
        pend = g;
      end
    end
    aok_prev = eaok;
    @(posedge aclk);
    #1;
  endtask

  // Masters hold a request stable until it is accepted, then may issue a new one.
  task automatic drive_masters(input int pct);
    for (int i = 0; i < NR; i++) begin
      if (!m_req[i] || aok_prev[i]) begin
        m_req[i]            = ($urandom_range(99) < pct);
        m_wr[i]             = 1'($urandom_range(1));
        m_size[2*i +: 2]    = 2'($urandom_range(2));
        m_wstrb[4*i +: 4]   = 4'($urandom_range(15));
        m_addr[32*i +: 32]  = $urandom;
        m_wdata[32*i +: 32] = $urandom;
      end
    end
  endtask

  task automatic drive_slave(input int aok_pct, input int dok_pct);
    s_addr_ok = ($urandom_range(99) < aok_pct);
    s_data_ok = (q.size() > 0) && ($urandom_range(99) < dok_pct);
    s_rdata   = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    aresetn = 1'b0; m_req = '0; m_wr = '0; m_size = '0; m_wstrb = '0;
    m_addr = '0; m_wdata = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;
    cycle(); cycle();
    aresetn = 1'b1;
    cycle();

    // Single read from master 0, response three cycles after acceptance.
    m_req = 2'b01; m_addr[31:0] = 32'h1c00_0000; m_wr = 2'b00; s_addr_ok = 1'b1;
    cycle();
    m_req = 2'b00; s_addr_ok = 1'b0;
    cycle(); cycle();
    s_data_ok = 1'b1; s_rdata = 32'hdead_beef;
    cycle();
    s_data_ok = 1'b0;
    cycle();

    // Slave stalls while master 1 joins: master 0 must keep the port.
    m_req = 2'b01; m_addr[31:0] = 32'h1000_0040; m_wdata[31:0] = 32'h1234_5678; m_wstrb[3:0] = 4'hf;
    cycle();
    m_req = 2'b11; m_addr[63:32] = 32'h2000_0080; m_wdata[63:32] = 32'h9abc_def0;
    for (int i = 0; i < 3; i++) cycle();
    s_addr_ok = 1'b1;
    cycle();
    m_req = 2'b10;
    cycle();
    m_req = 2'b00; s_addr_ok = 1'b0;
    for (int i = 0; i < 6; i++) begin drive_slave(0, 100); cycle(); end

    // Both masters busy, slave always accepts.
    for (int i = 0; i < 60; i++) begin drive_masters(90); drive_slave(100, 50); cycle(); end
    // Random stalls on both channels.
    for (int i = 0; i < 150; i++) begin drive_masters(70); drive_slave(35, 40); cycle(); end
    // No responses: in-flight limit must block new requests, then resume.
    for (int i = 0; i < 10; i++) begin drive_masters(100); drive_slave(100, 0); cycle(); end
    for (int i = 0; i < 10; i++) begin drive_masters(100); drive_slave(100, 100); cycle(); end

    // Drain, then a response with nothing in flight.
    m_req = '0;
    for (int i = 0; i < 12; i++) begin drive_slave(0, 100); cycle(); end
    s_data_ok = 1'b1;
    cycle();
    s_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin drive_masters(80); drive_slave(60, 0); cycle(); end

    // Reset in the middle of traffic.
    for (int i = 0; i < 40; i++) begin drive_masters(80); drive_slave(60, 50); cycle(); end
    aresetn = 1'b0;
    for (int i = 0; i < 2; i++) begin drive_masters(80); drive_slave(60, 50); cycle(); end
    aresetn = 1'b1;
    for (int i = 0; i < 150; i++) begin drive_masters(75); drive_slave(50, 45); cycle(); end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
